seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
- Downstream of the ALU operation blocks. Consumes the six 7-bit segment patterns (display0..display5) that an operation block produces.
- Drives a time-multiplexed 6-digit common-anode seven-segment panel through one shared segment bus and six active-low digit enables.
- Patterns are snapshotted once per frame so a digit never shows a mix of old and new data.
- A short per-slot ghost-blanking interval suppresses bleed between adjacent digits.

Parameters:
- DIVIDER, 50000, clock cycles per digit slot; legal range 2..2^20.
- GHOST, 500, cycles at the start of each slot with all enables off; must be < DIVIDER.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- display0  input  7  segment pattern for digit 0 (bit set = segment lit; 7'b0000000 = blank digit)
- display1  input  7  segment pattern for digit 1
- display2  input  7  segment pattern for digit 2
- display3  input  7  segment pattern for digit 3
- display4  input  7  segment pattern for digit 4
- display5  input  7  segment pattern for digit 5
- hold  input  1  1 = freeze the snapshot; scanning continues
- blank  input  1  1 = force the panel dark; scanning continues
- seg  output  7  shared segment bus, active-high, registered
- an  output  6  digit enables, active-low, registered; an[k] low selects digit k
- frame_tick  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Reset and timing:
  - One clock domain.
  - Reset is synchronous, active-low, sampled on the rising edge of clk; resetn low at any point aborts the scan immediately.
  - Reset values: slot counter cnt = 0, digit index idx = 0, all six snapshot registers = 0, seg = 7'b0000000, an = 6'b111111, frame_tick = 0.
- Counter:
  - cnt counts 0..DIVIDER-1 every cycle.
  - On cnt == DIVIDER-1: cnt wraps to 0 and idx advances 0,1,2,3,4,5,0 (modulo 6, never 6 or 7).
- Snapshot load:
  - Occurs on every cycle where cnt == 0 and idx == 0 and hold == 0. This includes the first cycle after reset release.
  - All six displayN inputs are captured into snap0..snap5 simultaneously.
  - frame_tick is registered: it is high in the cycle after the load cycle, for exactly one cycle.
  - With hold == 1 on the load cycle: no load and no frame_tick; the previous snapshot is kept.
  - Input changes between loads are invisible at the outputs.
- Output registers (updated each cycle from the pre-edge cnt/idx/blank; one cycle of latency):
  - If blank == 1: an = 6'b111111, seg = 0.
  - Else if cnt < GHOST: an = 6'b111111, seg = 0 (ghost interval).
  - Else: an = ~(6'b000001 << idx), seg = snap[idx].
  - Exactly one bit of an is low outside blank and ghost intervals; never more than one.
- Snapshot/display ordering:
  - A load on cycle t and the display of slot idx=0 are consistent: slot 0's first lit cycle uses the newly loaded snap0. This holds because GHOST >= 1 and the load precedes the lit part of the slot.
- blank and hold:
  - Neither affects cnt or idx; the frame period is always 6*DIVIDER cycles.
  - Deasserting blank re-enables output on the next cycle, mid-slot, without a ghost restart.
  - Asserting hold and blank simultaneously is legal; each acts independently.
- Reset mid-frame: outputs return to their reset values on the next edge. The first frame after release starts at idx 0 with a fresh snapshot.

Test Plan:
- DIVIDER=4, GHOST=1: reset then release with display0..5 = 7'h01,02,04,08,10,20 → frame_tick high at cycle 1. Then the per-slot pattern (an, seg) = (111111,0) for 1 cycle and (111110,01) for 3 cycles, followed by the same for 111101/02 through 011111/20. The pattern repeats every 24 cycles with frame_tick every 24 cycles.
- Change display3 to 7'h7F mid-frame during slot 1 → digit 3 still shows 7'h08 this frame; shows 7'h7F from the next frame.
- hold=1 across one frame boundary with display0 changed to 7'h3F → no frame_tick at that boundary; digit 0 keeps its old value. Release hold → 7'h3F appears after the next boundary.
- blank=1 for 10 cycles mid-slot 2 → an=111111 and seg=0 throughout. After release, slot timing is unchanged: idx is still where it would have been.
- resetn low for 1 cycle during slot 4 → next cycle an=111111, seg=0, frame_tick=0. Scanning restarts at digit 0 with a new snapshot.
- Assertion over a 1000-cycle random-input run: an never has two zero bits; idx stays in 0..5; frame_tick is never high on consecutive cycles.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexes six 7-segment patterns onto one common-anode panel.
//   All six patterns are snapshotted together at the start of each frame,
//   so a digit never shows a mix of old and new data. The first GHOST
//   cycles of every digit slot keep all enables off to stop bleed between
//   neighbouring digits.
//
// Ports:
//   clk         system clock
//   resetn      synchronous active-low reset
//   display0..5 segment patterns for digits 0..5 (bit set = segment lit)
//   hold        1 = keep the current snapshot; scanning continues
//   blank       1 = force the panel dark; scanning continues
//   seg         shared segment bus, active-high, registered
//   an          digit enables, active-low, registered; an[k] low = digit k
//   frame_tick  one-cycle pulse after a new snapshot has been taken
module seven_segment_scanner #(
    parameter int unsigned DIVIDER = 50000,   // cycles per digit slot, 2..2^20
    parameter int unsigned GHOST   = 500      // dark cycles per slot, < DIVIDER
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] display0,
    input  logic [6:0] display1,
    input  logic [6:0] display2,
    input  logic [6:0] display3,
    input  logic [6:0] display4,
    input  logic [6:0] display5,
    input  logic       hold,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam int unsigned CW = ($clog2(DIVIDER) > 0) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDER - 1);
    localparam logic [CW-1:0] GHOST_END = CW'(GHOST);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [6:0]    snap [6];

    logic          load;
    logic [6:0]    seg_d;
    logic [5:0]    an_d;
    logic [6:0]    snap_sel;

    always_comb begin
        load = (cnt == '0) && (idx == 3'd0) && !hold;
    end

    always_comb begin
        snap_sel = '0;
        case (idx)
            3'd0:    snap_sel = snap[0];
            3'd1:    snap_sel = snap[1];
            3'd2:    snap_sel = snap[2];
            3'd3:    snap_sel = snap[3];
            3'd4:    snap_sel = snap[4];
            3'd5:    snap_sel = snap[5];
            default: snap_sel = '0;
        endcase
    end

    // The load happens during the ghost part of slot 0, so the first lit
    // cycle of slot 0 already reads the freshly captured snap[0].
    always_comb begin
        seg_d = '0;
        an_d  = '1;
        if (!blank && (cnt >= GHOST_END)) begin
            seg_d = snap_sel;
            an_d  = ~(6'b000001 << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '{default: '0};
            seg        <= '0;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (load) begin
                snap[0] <= display0;
                snap[1] <= display1;
                snap[2] <= display2;
                snap[3] <= display3;
                snap[4] <= display4;
                snap[5] <= display5;
            end
            frame_tick <= load;
            seg        <= seg_d;
            an         <= an_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Directed bench for seven_segment_scanner with DIVIDER=4, GHOST=1.
//   Each clock edge is checked against frame arithmetic: edge e after reset
//   release shows slot (e/4)%6 at phase e%4, and a snapshot is taken on
//   edges where e%24 == 0 with hold low.
module tb_seven_segment_scanner;

    localparam int unsigned DIV   = 4;
    localparam int unsigned GH    = 1;
    localparam int unsigned FRAME = 6 * DIV;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] display0, display1, display2, display3, display4, display5;
    logic       hold, blank;
    logic [6:0] seg;
    logic [5:0] an;
    logic       frame_tick;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned e        = 0;
    logic [6:0]  exp_snap [6];
    logic        prev_ft  = 1'b0;

    seven_segment_scanner #(.DIVIDER(DIV), .GHOST(GH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .display0   (display0),
        .display1   (display1),
        .display2   (display2),
        .display3   (display3),
        .display4   (display4),
        .display5   (display5),
        .hold       (hold),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic tick();
        logic        ld;
        int unsigned s, p;
        logic [5:0]  ea;
        logic [6:0]  es;
        @(posedge clk);
        #1;
        if (!resetn) begin
            chk("rst_seg", seg, 7'h00);
            chk("rst_an", {1'b0, an}, 7'h3F);
            chk("rst_ft", {6'd0, frame_tick}, 7'h00);
            for (int i = 0; i < 6; i++) exp_snap[i] = '0;
            e = 0;
        end else begin
            ld = ((e % FRAME) == 0) && !hold;
            if (ld) begin
                exp_snap[0] = display0; exp_snap[1] = display1;
                exp_snap[2] = display2; exp_snap[3] = display3;
                exp_snap[4] = display4; exp_snap[5] = display5;
            end
            s = (e / DIV) % 6;
            p = e % DIV;
            if (blank || p < GH) begin
                ea = 6'h3F;
                es = 7'h00;
            end else begin
                ea = 6'h3F ^ (6'd1 << s);
                es = exp_snap[s];
            end
            chk("seg", seg, es);
            chk("an", {1'b0, an}, {1'b0, ea});
            chk("frame_tick", {6'd0, frame_tick}, {6'd0, ld});
            e++;
        end
        chk("an_one_low", {6'd0, ($countones(~an) <= 1)}, 7'd1);
        chk("idx_range", {6'd0, (dut.idx <= 3'd5)}, 7'd1);
        chk("ft_not_consec", {6'd0, (frame_tick && prev_ft)}, 7'd0);
        prev_ft = frame_tick;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 6; i++) exp_snap[i] = '0;
        resetn   = 1'b0;
        hold     = 1'b0;
        blank    = 1'b0;
        display0 = 7'h01; display1 = 7'h02; display2 = 7'h04;
        display3 = 7'h08; display4 = 7'h10; display5 = 7'h20;

        // reset state
        run(2);
        resetn = 1'b1;

        // first edge after release: snapshot taken, ghost interval
        run(1);
        chk("ft_first", {6'd0, frame_tick}, 7'd1);
        chk("an_first", {1'b0, an}, 7'h3F);
        run(1);
        chk("slot0_lit_seg", seg, 7'h01);
        chk("slot0_lit_an", {1'b0, an}, 7'b0111110);
        run(46);                              // e = 48

        // display3 change mid-frame during slot 1
        run(5);                               // e = 53
        display3 = 7'h7F;
        run(9);                               // last edge 61: slot 3 phase 1
        chk("d3_old_seg", seg, 7'h08);
        chk("d3_old_an", {1'b0, an}, 7'b0110111);
        run(24);                              // last edge 85
        chk("d3_new_seg", seg, 7'h7F);

        // hold across the frame boundary at edge 96
        hold     = 1'b1;
        display0 = 7'h3F;
        run(11);                              // last edge 96
        chk("hold_no_ft", {6'd0, frame_tick}, 7'd0);
        run(1);                               // edge 97: slot 0 phase 1
        chk("hold_d0_old", seg, 7'h01);
        hold = 1'b0;
        run(24);                              // last edge 121
        chk("hold_d0_new", seg, 7'h3F);

        // blank for 10 cycles starting mid-slot 2
        run(7);                               // e = 129
        blank = 1'b1;
        for (int k = 0; k < 10; k++) begin
            run(1);
            chk("blank_an", {1'b0, an}, 7'h3F);
            chk("blank_seg", seg, 7'h00);
        end
        blank = 1'b0;
        run(1);                               // edge 139: slot 4 phase 3
        chk("unblank_an", {1'b0, an}, 7'b0101111);
        chk("unblank_seg", seg, 7'h10);

        // one-cycle reset during slot 4
        run(21);                              // e = 161
        resetn = 1'b0;
        run(1);
        chk("midrst_an", {1'b0, an}, 7'h3F);
        chk("midrst_seg", seg, 7'h00);
        chk("midrst_ft", {6'd0, frame_tick}, 7'd0);
        resetn   = 1'b1;
        display0 = 7'h55;
        run(1);
        chk("restart_ft", {6'd0, frame_tick}, 7'd1);
        run(1);
        chk("restart_seg", seg, 7'h55);
        chk("restart_an", {1'b0, an}, 7'b0111110);

        // random-input run
        for (int k = 0; k < 1000; k++) begin
            display0 = 7'($urandom); display1 = 7'($urandom);
            display2 = 7'($urandom); display3 = 7'($urandom);
            display4 = 7'($urandom); display5 = 7'($urandom);
            hold     = ($urandom_range(0, 3) == 0);
            blank    = ($urandom_range(0, 7) == 0);
            run(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
